// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the 9-bit serial CRC block.
package crc_pkg;

  localparam int              CRC9_W    = 9;
  localparam logic [CRC9_W-1:0] CRC9_POLY = 9'h103;  // y^8 + y + 1 (y^9 implied)

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit LFSR division step: feeds one message bit into the remainder register.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = CRC9_W,
  parameter logic [CRC_W-1:0] POLY  = CRC9_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  // Feedback is the outgoing remainder MSB combined with the incoming message bit
  always_comb begin
    fb      = crc_in[CRC_W-1] ^ bit_in;
    crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/serial_crc.sv
// Bit-serial CRC generator: captures a message once after reset, divides it
// MSB-first through an LFSR, then holds the remainder until the next reset.
module serial_crc
  import crc_pkg::*;
#(
  parameter int               MSG_W = 10,
  parameter int               CRC_W = CRC9_W,
  parameter logic [CRC_W-1:0] POLY  = CRC9_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MSG_W-1:0] data_in,
  output logic [CRC_W-1:0] data_out
);

  localparam int CNT_W = $clog2(MSG_W + 1);

  crc_state_e       state_q, state_d;
  logic [MSG_W-1:0] msg_sr_q, msg_sr_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] crc_step;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .bit_in  (msg_sr_q[MSG_W-1]),
    .crc_out (crc_step)
  );

  // State and datapath registers; reset clears everything so data_out drops to 0 at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      msg_sr_q <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      msg_sr_q <= msg_sr_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: load once, shift MSG_W bits, then hold in DONE
  always_comb begin
    state_d  = state_q;
    msg_sr_d = msg_sr_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      LOAD: begin
        msg_sr_d = data_in;
        crc_d    = '0;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        crc_d    = crc_step;
        msg_sr_d = {msg_sr_q[MSG_W-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MSG_W - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign data_out = crc_q;

endmodule

// File: tb/tb_serial_crc.sv
// Directed and random self-checking bench for serial_crc.
`timescale 1ns/1ps
module tb_serial_crc;

  logic       clk;
  logic       reset;
  logic [9:0] data_in;
  logic [8:0] data_out;

  int n_vec;
  int n_err;

  serial_crc dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Long division of {m, 9'b0} by G = 10'b1100000011
  function automatic logic [8:0] ref_crc(input logic [9:0] m);
    logic [18:0] r;
    logic [9:0]  g;
    g = 10'b1100000011;
    r = {m, 9'b0};
    for (int i = 18; i >= 9; i--) begin
      if (r[i]) r[i -: 10] = r[i -: 10] ^ g;
    end
    return r[8:0];
  endfunction

  task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: data_out=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply a word, pulse reset, and leave the bench just after edge 1 (LOAD)
  task automatic start_word(input logic [9:0] w);
    @(negedge clk);
    data_in = w;
    reset   = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_shift();
    repeat (10) @(posedge clk);
    #1;
  endtask

  logic [8:0] steps [10];
  logic [9:0] w;
  logic [8:0] held;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    data_in = 10'h155;
    reset   = 1'b1;
    steps = '{9'b100000011, 9'b100000101, 9'b000001010, 9'b100010111, 9'b100101101,
              9'b101011001, 9'b010110010, 9'b101100100, 9'b011001000, 9'b010010011};

    // Reset state: asynchronous clear, checked between edges
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_vec("reset_state", data_out, 9'b0);
    @(negedge clk);
    reset = 1'b1;

    // Message equal to G divides evenly; result held afterwards
    start_word(10'b1100000011);
    finish_shift();
    check_vec("g_word", data_out, 9'b000000000);
    repeat (5) @(posedge clk);
    #1 check_vec("g_word_held", data_out, 9'b000000000);

    // Worked example with every intermediate remainder
    start_word(10'b1011001011);
    check_vec("ex_load", data_out, 9'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 check_vec($sformatf("ex_step%0d", k + 1), data_out, steps[k]);
    end

    // y^9 mod G and the all-zero word
    start_word(10'b0000000001);
    finish_shift();
    check_vec("y9_mod_g", data_out, 9'b100000011);
    start_word(10'b0000000000);
    finish_shift();
    check_vec("zero_word", data_out, 9'b0);

    // data_in changes during SHIFT and in DONE must not matter
    start_word(10'b1011001011);
    repeat (3) @(posedge clk);
    data_in = 10'b0111010100;
    repeat (7) @(posedge clk);
    #1 check_vec("shift_change", data_out, 9'b010010011);
    held = data_out;
    for (int k = 0; k < 5; k++) begin
      data_in = 10'($urandom);
      repeat (5) @(posedge clk);
      #1 check_vec($sformatf("done_hold%0d", k), data_out, 9'b010010011);
    end

    // Reset mid-computation: immediate clear, then clean recompute
    start_word(10'b1011001011);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_vec("mid_reset_async", data_out, 9'b0);
    data_in = 10'b1110001101;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    finish_shift();
    check_vec("mid_reset_recompute", data_out, ref_crc(10'b1110001101));

    // Random words against the long-division model
    for (int k = 0; k < 100; k++) begin
      w = 10'($urandom);
      start_word(w);
      finish_shift();
      check_vec($sformatf("rand%0d_%b", k, w), data_out, ref_crc(w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_crc.md
# serial_crc

Bit-serial CRC generator using an LFSR with generator polynomial G(y) = y^9 + y^8 + y + 1. After reset it captures a 10-bit message and shifts it MSB-first through a 9-bit division register, one bit per clock. The result is the remainder M(y)·y^9 mod G(y), which is then held on `data_out`. It is a standalone datapath leaf used to append or check a 9-bit CRC on short fixed-length frames.

## Interface
- `MSG_W`, default 10: message width in bits.
- `CRC_W`, default 9: CRC width; equals the degree of G.
- `POLY`, default 9'h103: G without its y^9 term (y^8 + y + 1).
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `data_in`  in  MSG_W  message word; bit MSG_W-1 is the highest-order coefficient and is shifted first.
- `data_out`  out  CRC_W  CRC register contents; the final remainder once computation completes.

## Operation
- Internal state:
  - `msg_sr[MSG_W-1:0]`: message shift register.
  - `crc[CRC_W-1:0]`: division register; drives `data_out` directly.
  - `cnt`: bit counter, 0..MSG_W.
  - FSM state: LOAD, SHIFT, DONE.
- LOAD:
  - Next edge: `msg_sr <= data_in`, `crc <= 0`, `cnt <= 0`.
  - Then go to SHIFT.
- SHIFT, each edge:
  - `fb = crc[CRC_W-1] ^ msg_sr[MSG_W-1]`.
  - `crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)`.
  - `msg_sr <= msg_sr << 1`; `cnt <= cnt + 1`.
  - When `cnt` reaches MSG_W-1 this edge (MSG_W bits consumed), go to DONE.
- This is direct-division form: no trailing zero bits are shifted. The result equals long division of {data_in, 9'b0} by 10'b1100000011.
- DONE:
  - `crc` and `data_out` hold indefinitely.
  - `data_in` is ignored.
  - Only reset restarts the block.
- `data_in` is sampled once, in LOAD. Later changes have no effect on the current computation.

## Timing
- Reset asserted (`reset`=0), immediately and asynchronously:
  - `data_out` = 0, `crc` = 0, `msg_sr` = 0, `cnt` = 0.
  - State = LOAD.
- After reset deassertion:
  - Edge 1: LOAD captures `data_in`.
  - Edges 2..11: ten SHIFT steps. `data_out` shows the running remainder after each step.
  - Edge 11: final remainder valid, state enters DONE.
  - Latency from first edge to valid result: 11 clocks.
- Reset asserted mid-SHIFT or in DONE: all state clears at once; the computation is discarded.
- Reset deassertion must meet recovery/removal timing against `clk`. Upstream provides a synchronised release.

## Structure
- Shared package `crc_pkg`:
  - Constants `CRC9_POLY = 9'h103`, `CRC9_W = 9`.
  - FSM state typedef {LOAD, SHIFT, DONE}.
- Natural sub-module `crc_lfsr_step`: combinational one-bit update `(crc, bit) -> crc_next`, parameterised by CRC_W and POLY. The top holds the FSM, counter and message register.

## Test plan
- `data_in` = 10'b1100000011 (= G), reset pulse → `data_out` = 9'b000000000 at edge 11 and held.
- `data_in` = 10'b1011001011 → `data_out` = 9'b010010011 at edge 11; all earlier edges show intermediate values.
- `data_in` = 10'b0000000001 → `data_out` = 9'b100000011 (y^9 mod G); `data_in` = 0 → `data_out` = 0.
- Change `data_in` during SHIFT and in DONE → result still matches the word captured at edge 1; DONE value stable for 20+ cycles.
- Assert `reset` at edge 5 of a computation → `data_out` = 0 immediately, without waiting for a clock. After release, a full 11-edge recompute yields the correct remainder for the current `data_in`.
- Random `data_in` (≥100 words, reset between each) → `data_out` matches a bench reference model (long division of {data_in, 9'b0} by 10'b1100000011).
